// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl - prioritised interrupt controller for the j1 core.
//
// Latches edges on up to NSRC asynchronous interrupt sources into a pending
// register. It masks them with an enable register and arbitrates by fixed
// priority, with index 0 the highest. One request at a time is presented on
// interrupt_request. The request, acknowledge and end-of-interrupt steps are
// sequenced over the CPU IO bus.
//
// Register map (offset = mem_addr[3:0], block selected by mem_addr[15:4]):
//   0 PEND    R: pending bits, W: write-1-to-clear
//   2 ENABLE  R/W: source mask
//   4 VECTOR  R: {valid, 11'b0, index}; a valid read while requesting is the ack
//   6 EOI     W: any write ends service
//   8 LEVEL   R/W: per-source level sensitivity (only with IRQ_LEVEL_EN)
//
// Optional feature: define IRQ_LEVEL_EN to add the LEVEL register.
//
// Ports:
//   clk               system clock
//   resetq            asynchronous active-low reset
//   irq_src           raw interrupt sources, asynchronous to clk
//   io_rd, io_wr      one-cycle CPU IO strobes
//   mem_addr, dout    CPU IO address and write data
//   io_din            registered read data, 0 after a read to another block
//   interrupt_request level request to the core, high while requesting
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int unsigned NSRC = 8,
    parameter logic [15:0] BASE = 16'h0100
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic [NSRC-1:0] irq_src,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [15:0]     mem_addr,
    input  logic [15:0]     dout,
    output logic [15:0]     io_din,
    output logic            interrupt_request
);

    typedef enum logic [1:0] {StIdle, StReq, StSvc} state_e;

    localparam logic [3:0] OffPend   = 4'h0;
    localparam logic [3:0] OffEnable = 4'h2;
    localparam logic [3:0] OffVector = 4'h4;
    localparam logic [3:0] OffEoi    = 4'h6;
`ifdef IRQ_LEVEL_EN
    localparam logic [3:0] OffLevel  = 4'h8;
`endif

    logic [NSRC-1:0] r_sync1, r_sync2, r_prev;
    logic [NSRC-1:0] r_pend, r_enable;
`ifdef IRQ_LEVEL_EN
    logic [NSRC-1:0] r_level;
`endif
    state_e          r_state;
    logic [3:0]      r_isr;
    logic [15:0]     r_din;
    logic            r_irq;

    logic            w_hit, w_rd, w_wr;
    logic [3:0]      w_off;
    logic [NSRC-1:0] w_rise, w_act, w_low, w_pend_next;
    logic            w_valid, w_ack, w_eoi;
    logic [3:0]      w_idx;
    logic [15:0]     w_vector, w_rdata;
    state_e          w_state_next;
    logic            w_unused;

    assign w_hit = (mem_addr[15:4] == BASE[15:4]);
    assign w_off = mem_addr[3:0];
    assign w_rd  = io_rd & w_hit;
    assign w_wr  = io_wr & w_hit;

    // Rising edge of the synchronised input.
    assign w_rise = r_sync2 & ~r_prev;

    assign w_act   = r_pend & r_enable;
    assign w_valid = |w_act;

    // Lowest-numbered active source wins; w_low is its one-hot form.
    always_comb begin
        w_idx = 4'h0;
        w_low = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_idx    = 4'(i);
                w_low    = '0;
                w_low[i] = 1'b1;
            end
        end
    end

    assign w_vector = {w_valid, 11'b0, w_idx};
    assign w_ack    = w_rd && (w_off == OffVector) && (r_state == StReq) && w_valid;
    assign w_eoi    = w_wr && (w_off == OffEoi);

    // Clears are applied first so a same-cycle edge always wins.
    always_comb begin
        w_pend_next = r_pend;
        if (w_wr && (w_off == OffPend)) begin
            w_pend_next = w_pend_next & ~dout[NSRC-1:0];
        end
        if (w_ack) begin
            w_pend_next = w_pend_next & ~w_low;
        end
        w_pend_next = w_pend_next | w_rise;
`ifdef IRQ_LEVEL_EN
        w_pend_next = (w_pend_next & ~r_level) | (r_sync2 & r_level);
`endif
    end

    always_comb begin
        w_rdata = 16'h0;
        case (w_off)
            OffPend:   w_rdata[NSRC-1:0] = r_pend;
            OffEnable: w_rdata[NSRC-1:0] = r_enable;
            OffVector: w_rdata           = w_vector;
`ifdef IRQ_LEVEL_EN
            OffLevel:  w_rdata[NSRC-1:0] = r_level;
`endif
            default:   w_rdata           = 16'h0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_valid) w_state_next = StReq;
            end
            StReq: begin
                if (w_ack) begin
                    w_state_next = StSvc;
                end else if (!w_valid) begin
                    w_state_next = StIdle;
                end
            end
            StSvc: begin
                if (w_eoi) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_pend   <= '0;
            r_enable <= '0;
`ifdef IRQ_LEVEL_EN
            r_level  <= '0;
`endif
            r_state  <= StIdle;
            r_isr    <= 4'h0;
            r_din    <= 16'h0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pend  <= w_pend_next;
            r_state <= w_state_next;
            // Registered copy of the state decode so the request is glitch-free.
            r_irq   <= (w_state_next == StReq);
            if (w_wr && (w_off == OffEnable)) begin
                r_enable <= dout[NSRC-1:0];
            end
`ifdef IRQ_LEVEL_EN
            if (w_wr && (w_off == OffLevel)) begin
                r_level <= dout[NSRC-1:0];
            end
`endif
            if (w_ack) begin
                r_isr <= w_idx;
            end
            if (io_rd) begin
                r_din <= w_hit ? w_rdata : 16'h0;
            end
        end
    end

    assign io_din            = r_din;
    assign interrupt_request = r_irq;

    // Upper write-data bits and the in-service index have no reader here.
    assign w_unused = ^{dout, r_isr};

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl - self-checking bench for irq_ctrl.
// Directed steps followed by a randomized phase. Every cycle, the DUT is
// compared against a behavioural reference model of the controller.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int unsigned NSRC = 8;
    localparam logic [15:0] BASE = 16'h0100;

    logic            clk      = 1'b0;
    logic            resetq   = 1'b0;
    logic [NSRC-1:0] irq_src  = '0;
    logic            io_rd    = 1'b0;
    logic            io_wr    = 1'b0;
    logic [15:0]     mem_addr = 16'h0;
    logic [15:0]     dout     = 16'h0;
    logic [15:0]     io_din;
    logic            interrupt_request;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending/enable/level sets, a 3-deep history of the raw
    // input as seen at the last three edges, the read latch and a phase number
    // (0 idle, 1 requesting, 2 in service).
    logic [NSRC-1:0] m_pend, m_en, m_level, m_h1, m_h2, m_h3;
    logic [15:0]     m_din;
    int              m_state;

    logic [3:0] offs [6] = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'h5};

    irq_ctrl #(
        .NSRC (NSRC),
        .BASE (BASE)
    ) u_dut (
        .clk               (clk),
        .resetq            (resetq),
        .irq_src           (irq_src),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .mem_addr          (mem_addr),
        .dout              (dout),
        .io_din            (io_din),
        .interrupt_request (interrupt_request)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic m_reset();
        m_pend  = '0;
        m_en    = '0;
        m_level = '0;
        m_h1    = '0;
        m_h2    = '0;
        m_h3    = '0;
        m_din   = 16'h0;
        m_state = 0;
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic step();
        logic [NSRC-1:0] act, pend_n;
        logic [15:0]     rdata;
        logic            valid, sel, ack;
        logic [3:0]      off;
        int              idx, st_n;
        act   = m_pend & m_en;
        valid = (act != '0);
        idx   = 0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (act[i]) begin
                idx = i;
                break;
            end
        end
        sel = (mem_addr[15:4] == BASE[15:4]);
        off = mem_addr[3:0];
        case (off)
            4'h0:    rdata = 16'(m_pend);
            4'h2:    rdata = 16'(m_en);
            4'h4:    rdata = {valid, 11'b0, 4'(idx)};
`ifdef IRQ_LEVEL_EN
            4'h8:    rdata = 16'(m_level);
`endif
            default: rdata = 16'h0;
        endcase
        ack    = io_rd && sel && (off == 4'h4) && (m_state == 1) && valid;
        pend_n = m_pend;
        if (io_wr && sel && off == 4'h0) pend_n = pend_n & ~dout[NSRC-1:0];
        if (ack) pend_n[idx] = 1'b0;
        pend_n = pend_n | (m_h2 & ~m_h3);
`ifdef IRQ_LEVEL_EN
        for (int i = 0; i < int'(NSRC); i++) begin
            if (m_level[i]) pend_n[i] = m_h2[i];
        end
`endif
        st_n = m_state;
        if (m_state == 0 && valid) st_n = 1;
        else if (m_state == 1 && ack) st_n = 2;
        else if (m_state == 1 && !valid) st_n = 0;
        else if (m_state == 2 && io_wr && sel && off == 4'h6) st_n = 0;

        @(posedge clk);
        #1;
        if (!resetq) begin
            m_reset();
        end else begin
            if (io_wr && sel && off == 4'h2) m_en = dout[NSRC-1:0];
`ifdef IRQ_LEVEL_EN
            if (io_wr && sel && off == 4'h8) m_level = dout[NSRC-1:0];
`endif
            if (io_rd) m_din = sel ? rdata : 16'h0;
            m_pend  = pend_n;
            m_state = st_n;
            m_h3    = m_h2;
            m_h2    = m_h1;
            m_h1    = irq_src;
        end
        chk("model_req", {15'b0, interrupt_request}, {15'b0, m_state == 1});
        chk("model_din", io_din, m_din);
    endtask

    task automatic wr(input logic [3:0] off, input logic [15:0] d);
        io_wr    = 1'b1;
        mem_addr = BASE | 16'(off);
        dout     = d;
        step();
        io_wr = 1'b0;
        dout  = 16'h0;
    endtask

    task automatic rd(input logic [3:0] off);
        io_rd    = 1'b1;
        mem_addr = BASE | 16'(off);
        step();
        io_rd = 1'b0;
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        irq_src = irq_src | m;
        step();
        irq_src = irq_src & ~m;
    endtask

    // Bounded wait for the request; an expiry shows up as a failed check.
    task automatic wait_req(output int cnt);
        cnt = 0;
        while (!interrupt_request && cnt < 12) begin
            step();
            cnt++;
        end
        chk("req_wait", {15'b0, interrupt_request}, 16'h0001);
    endtask

    initial begin
        int cnt;
        m_reset();
        repeat (3) step();
        chk("rst_req", {15'b0, interrupt_request}, 16'h0000);
        chk("rst_din", io_din, 16'h0000);
        resetq = 1'b1;

        // Reset while requesting.
        wr(4'h2, 16'h0001);
        pulse(8'h01);
        wait_req(cnt);
        resetq = 1'b0;
        #1;
        chk("t1_async_req", {15'b0, interrupt_request}, 16'h0000);
        m_reset();
        step();
        step();
        resetq = 1'b1;
        rd(4'h0);
        chk("t1_pend", io_din, 16'h0000);
        rd(4'h2);
        chk("t1_enable", io_din, 16'h0000);

        // Single source: latency, acknowledge, EOI.
        wr(4'h2, 16'h0004);
        pulse(8'h04);
        wait_req(cnt);
        chk("t2_latency", {15'b0, (cnt + 1 >= 4) && (cnt + 1 <= 5)}, 16'h0001);
        rd(4'h4);
        chk("t2_vector", io_din, 16'h8002);
        chk("t2_req_drop", {15'b0, interrupt_request}, 16'h0000);
        rd(4'h0);
        chk("t2_pend", io_din, 16'h0000);
        wr(4'h6, 16'h0000);
        step();
        chk("t2_after_eoi", {15'b0, interrupt_request}, 16'h0000);

        // Simultaneous sources: priority order.
        wr(4'h2, 16'h00FF);
        irq_src = 8'h22;
        step();
        irq_src = 8'h00;
        wait_req(cnt);
        rd(4'h4);
        chk("t3_vec_hi", io_din, 16'h8001);
        wr(4'h6, 16'h0000);
        wait_req(cnt);
        rd(4'h4);
        chk("t3_vec_lo", io_din, 16'h8005);
        wr(4'h6, 16'h0000);

        // Masked pending, unmask, W1C withdraws the request.
        wr(4'h2, 16'h0000);
        pulse(8'h08);
        repeat (4) step();
        rd(4'h0);
        chk("t4_pend", io_din, 16'h0008);
        chk("t4_no_req", {15'b0, interrupt_request}, 16'h0000);
        wr(4'h2, 16'h0008);
        chk("t4_req_1clk", {15'b0, interrupt_request}, 16'h0000);
        step();
        chk("t4_req_2clk", {15'b0, interrupt_request}, 16'h0001);
        wr(4'h0, 16'h0008);
        rd(4'h4);
        chk("t4_vector", io_din, 16'h0000);
        chk("t4_req_gone", {15'b0, interrupt_request}, 16'h0000);

        // Re-trigger during service; W1C racing an edge.
        wr(4'h2, 16'h0001);
        pulse(8'h01);
        wait_req(cnt);
        rd(4'h4);
        chk("t5_vector", io_din, 16'h8000);
        pulse(8'h01);
        repeat (4) step();
        rd(4'h0);
        chk("t5_pend", io_din, 16'h0001);
        chk("t5_svc_quiet", {15'b0, interrupt_request}, 16'h0000);
        wr(4'h6, 16'h0000);
        step();
        chk("t5_reassert", {15'b0, interrupt_request}, 16'h0001);
        rd(4'h4);
        chk("t5_vector2", io_din, 16'h8000);
        wr(4'h6, 16'h0000);
        irq_src = 8'h02;
        step();
        step();
        wr(4'h0, 16'h0002);
        rd(4'h0);
        chk("t5_set_wins", io_din, 16'h0002);
        irq_src = 8'h00;
        wr(4'h0, 16'h0002);
        rd(4'h0);
        chk("t5_w1c", io_din, 16'h0000);

        // Miss read returns zero.
        io_rd    = 1'b1;
        mem_addr = 16'h0204;
        step();
        io_rd = 1'b0;
        chk("miss_read", io_din, 16'h0000);

`ifdef IRQ_LEVEL_EN
        wr(4'h8, 16'h0001);
        rd(4'h8);
        chk("t6_level", io_din, 16'h0001);
        wr(4'h2, 16'h0001);
        irq_src = 8'h01;
        wait_req(cnt);
        rd(4'h4);
        chk("t6_vector", io_din, 16'h8000);
        rd(4'h0);
        chk("t6_pend_held", io_din, 16'h0001);
        wr(4'h6, 16'h0000);
        step();
        chk("t6_reassert", {15'b0, interrupt_request}, 16'h0001);
        wr(4'h2, 16'h0000);
        irq_src = 8'h00;
        step();
        step();
        rd(4'h0);
        chk("t6_pend_2clk", io_din, 16'h0001);
        rd(4'h0);
        chk("t6_pend_3clk", io_din, 16'h0000);
`endif

        // Randomized traffic against the model.
        wr(4'h2, 16'($urandom));
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [3:0]  off;
            r        = int'($urandom_range(0, 9));
            off      = offs[$urandom_range(0, 5)];
            io_rd    = (r < 3);
            io_wr    = (r >= 3) && (r < 6);
            mem_addr = ($urandom_range(0, 7) == 0) ? (16'h0200 | 16'(off)) : (BASE | 16'(off));
            dout     = 16'($urandom);
            irq_src  = irq_src ^ NSRC'($urandom & $urandom & $urandom);
            step();
        end
        io_rd = 1'b0;
        io_wr = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
